// File: rtl/masked_associative_data_array.sv
// Set-associative cache data array with per-byte write masks, multi-way writes,
// 1- or 2-cycle registered reads, a zeroing init sweep after reset and a multi-hot read flag.
//   state    | meaning
//   ST_INIT  | zero one set per cycle, accesses ignored
//   ST_READY | array initialised, reads and writes accepted
module masked_associative_data_array #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int NUMBER_WAYS                 = 16,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
    parameter int BYTE_MASK_WIDTH             = SINGLE_ELEMENT_SIZE_IN_BITS / 8,
    parameter int READ_LATENCY                = 1
) (
    input  logic                                               clk_in,
    input  logic                                               reset_in,
    input  logic                                               access_en_in,
    input  logic                                               write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                   access_set_addr_in,
    input  logic [NUMBER_WAYS-1:0]                             way_select_in,
    input  logic [BYTE_MASK_WIDTH-1:0]                         write_byte_mask_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             write_single_element_in,
    output logic                                               ready_out,
    output logic                                               read_valid_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             read_single_element_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS*NUMBER_WAYS-1:0] read_set_element_out,
    output logic                                               read_multi_way_error_out
);
    localparam int ELEM_W = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int SET_W  = SINGLE_ELEMENT_SIZE_IN_BITS * NUMBER_WAYS;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

    logic [0:0]                       r_state;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] r_init_set;
    logic [ELEM_W-1:0]                r_mem [NUMBER_SETS][NUMBER_WAYS];

    logic              w_init_wr;
    logic              w_wr;
    logic              w_rd;
    logic              w_multi;
    logic [SET_W-1:0]  w_rd_set;
    logic [ELEM_W-1:0] w_rd_single;

    assign w_init_wr = (r_state == ST_INIT);
    assign w_wr      = (r_state == ST_READY) && access_en_in && write_en_in;
    assign w_rd      = (r_state == ST_READY) && access_en_in && !write_en_in;
    assign w_multi   = |(way_select_in & (way_select_in - NUMBER_WAYS'(1)));
    assign ready_out = (r_state == ST_READY);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= ST_INIT;
            r_init_set <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_set <= r_init_set + 1'b1;
            if (r_init_set == LAST_SET)
                r_state <= ST_READY;
        end
    end

    // Storage is deliberately not reset; the init sweep clears it instead.
    always_ff @(posedge clk_in) begin
        if (w_init_wr) begin
            for (int w = 0; w < NUMBER_WAYS; w++)
                r_mem[r_init_set][w] <= '0;
        end else if (w_wr) begin
            for (int w = 0; w < NUMBER_WAYS; w++)
                for (int b = 0; b < BYTE_MASK_WIDTH; b++)
                    if (way_select_in[w] && write_byte_mask_in[b])
                        r_mem[access_set_addr_in][w][8*b +: 8] <= write_single_element_in[8*b +: 8];
        end
    end

    // Walk downwards so the lowest-indexed selected way wins.
    always_comb begin
        w_rd_set    = '0;
        w_rd_single = '0;
        for (int w = NUMBER_WAYS - 1; w >= 0; w--) begin
            w_rd_set[w*ELEM_W +: ELEM_W] = r_mem[access_set_addr_in][w];
            if (way_select_in[w])
                w_rd_single = r_mem[access_set_addr_in][w];
        end
    end

    logic              r_s1_valid;
    logic              r_s1_err;
    logic [ELEM_W-1:0] r_s1_single;
    logic [SET_W-1:0]  r_s1_set;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_s1_valid  <= 1'b0;
            r_s1_err    <= 1'b0;
            r_s1_single <= '0;
            r_s1_set    <= '0;
        end else begin
            r_s1_valid <= w_rd;
            r_s1_err   <= w_rd && w_multi;
            if (w_rd) begin
                r_s1_single <= w_rd_single;
                r_s1_set    <= w_rd_set;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_s2_valid;
            logic              r_s2_err;
            logic [ELEM_W-1:0] r_s2_single;
            logic [SET_W-1:0]  r_s2_set;

            always_ff @(posedge clk_in or posedge reset_in) begin
                if (reset_in) begin
                    r_s2_valid  <= 1'b0;
                    r_s2_err    <= 1'b0;
                    r_s2_single <= '0;
                    r_s2_set    <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_err   <= r_s1_err;
                    if (r_s1_valid) begin
                        r_s2_single <= r_s1_single;
                        r_s2_set    <= r_s1_set;
                    end
                end
            end

            assign read_valid_out           = r_s2_valid;
            assign read_multi_way_error_out = r_s2_err;
            assign read_single_element_out  = r_s2_single;
            assign read_set_element_out     = r_s2_set;
        end else begin : g_lat1
            assign read_valid_out           = r_s1_valid;
            assign read_multi_way_error_out = r_s1_err;
            assign read_single_element_out  = r_s1_single;
            assign read_set_element_out     = r_s1_set;
        end
    endgenerate
endmodule

// File: tb/tb_masked_associative_data_array.sv
// Drives a latency-1 and a latency-2 instance in lockstep and checks both against
// an array model with per-read expectation queues.
module tb_masked_associative_data_array;
    localparam int SZ = 64;
    localparam int NS = 64;
    localparam int NW = 16;
    localparam int AW = 6;
    localparam int BW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           acc_en = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [NW-1:0]  sel = '0;
    logic [BW-1:0]  mask = '0;
    logic [SZ-1:0]  wdata = '0;

    logic           rdy1, v1, e1, rdy2, v2, e2;
    logic [SZ-1:0]  s1, s2;
    logic [SZ*NW-1:0] set1, set2;

    always #5 clk = ~clk;

    masked_associative_data_array #(.READ_LATENCY(1)) u_dut1 (
        .clk_in(clk), .reset_in(rst), .access_en_in(acc_en), .write_en_in(wr_en),
        .access_set_addr_in(addr), .way_select_in(sel), .write_byte_mask_in(mask),
        .write_single_element_in(wdata), .ready_out(rdy1), .read_valid_out(v1),
        .read_single_element_out(s1), .read_set_element_out(set1),
        .read_multi_way_error_out(e1));

    masked_associative_data_array #(.READ_LATENCY(2)) u_dut2 (
        .clk_in(clk), .reset_in(rst), .access_en_in(acc_en), .write_en_in(wr_en),
        .access_set_addr_in(addr), .way_select_in(sel), .write_byte_mask_in(mask),
        .write_single_element_in(wdata), .ready_out(rdy2), .read_valid_out(v2),
        .read_single_element_out(s2), .read_set_element_out(set2),
        .read_multi_way_error_out(e2));

    typedef struct {
        int               due;
        logic [SZ-1:0]    single;
        logic [SZ*NW-1:0] set;
        logic             err;
    } rd_t;

    rd_t              q1[$];
    rd_t              q2[$];
    logic [SZ-1:0]    mdl [NS][NW];
    logic [SZ-1:0]    last_s [2];
    logic [SZ*NW-1:0] last_set [2];
    int               cyc = 0;
    int               e_done = 0;
    int               tests = 0;
    int               fails = 0;

    task automatic cmp(input string tag, input logic [SZ-1:0] obs, input logic [SZ-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input int k, input logic rv, input logic [SZ-1:0] rs,
                       input logic [SZ*NW-1:0] rset, input logic rerr);
        rd_t  e;
        logic ev;
        ev = 1'b0;
        if (k == 1) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin ev = 1'b1; e = q1.pop_front(); end
        end else begin
            if (q2.size() > 0 && q2[0].due == cyc) begin ev = 1'b1; e = q2.pop_front(); end
        end
        cmp($sformatf("valid_L%0d_c%0d", k, cyc), SZ'(rv), SZ'(ev));
        if (ev) begin
            last_s[k-1]   = e.single;
            last_set[k-1] = e.set;
            cmp($sformatf("err_L%0d_c%0d", k, cyc), SZ'(rerr), SZ'(e.err));
        end
        cmp($sformatf("single_L%0d_c%0d", k, cyc), rs, last_s[k-1]);
        for (int w = 0; w < NW; w++)
            cmp($sformatf("set_w%0d_L%0d_c%0d", w, k, cyc), rset[w*SZ +: SZ], last_set[k-1][w*SZ +: SZ]);
    endtask

    task automatic step(input logic a_en, input logic a_wr, input logic [AW-1:0] a,
                        input logic [NW-1:0] s, input logic [BW-1:0] m, input logic [SZ-1:0] d);
        rd_t  e;
        logic found;
        acc_en = a_en; wr_en = a_wr; addr = a; sel = s; mask = m; wdata = d;
        if (a_en && e_done >= NS) begin
            if (a_wr) begin
                for (int w = 0; w < NW; w++)
                    for (int b = 0; b < BW; b++)
                        if (s[w] && m[b]) mdl[a][w][8*b +: 8] = d[8*b +: 8];
            end else begin
                found    = 1'b0;
                e.single = '0;
                for (int w = 0; w < NW; w++) begin
                    e.set[w*SZ +: SZ] = mdl[a][w];
                    if (s[w] && !found) begin e.single = mdl[a][w]; found = 1'b1; end
                end
                e.err = ($countones(s) > 1);
                e.due = cyc + 1; q1.push_back(e);
                e.due = cyc + 2; q2.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        e_done++;
        acc_en = 1'b0;
        cmp($sformatf("ready_L1_e%0d", e_done), SZ'(rdy1), SZ'(e_done >= NS));
        cmp($sformatf("ready_L2_e%0d", e_done), SZ'(rdy2), SZ'(e_done >= NS));
        chk(1, v1, s1, set1, e1);
        chk(2, v2, s2, set2, e2);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [NW-1:0] s);
        step(1'b1, 1'b0, a, s, '0, {$urandom, $urandom});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] s, input logic [BW-1:0] m,
                      input logic [SZ-1:0] d);
        step(1'b1, 1'b1, a, s, m, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic rand_step();
        int op;
        int r;
        logic [NW-1:0] s;
        op = $urandom_range(0, 3);
        r  = $urandom_range(0, 5);
        if (r == 0)      s = '0;
        else if (r == 1) s = NW'($urandom);
        else             s = NW'(1) << $urandom_range(0, NW - 1);
        if (op == 0)      idle(1);
        else if (op == 1) wr(AW'($urandom_range(0, 7)), NW'($urandom), BW'($urandom), {$urandom, $urandom});
        else              rd(AW'($urandom_range(0, 7)), s);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        acc_en = 1'b0;
        #1;
        cmp("rst_ready_L1", SZ'(rdy1), '0);
        cmp("rst_ready_L2", SZ'(rdy2), '0);
        cmp("rst_valid_L1", SZ'(v1), '0);
        cmp("rst_valid_L2", SZ'(v2), '0);
        cmp("rst_err_L1", SZ'(e1), '0);
        cmp("rst_err_L2", SZ'(e2), '0);
        cmp("rst_single_L1", s1, '0);
        cmp("rst_single_L2", s2, '0);
        cmp("rst_set_or_L1", SZ'(|set1), '0);
        cmp("rst_set_or_L2", SZ'(|set2), '0);
        q1.delete();
        q2.delete();
        for (int k = 0; k < 2; k++) begin last_s[k] = '0; last_set[k] = '0; end
        for (int a = 0; a < NS; a++)
            for (int w = 0; w < NW; w++) mdl[a][w] = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        e_done = 0;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < NS; i++) rand_step();
        rd(7, 16'h0008);
        idle(2);

        for (int i = 0; i < 16; i++) wr(AW'(i), NW'(1) << i, 8'hFF, 64'h1111_0000_0000_0000 + 64'(i));
        for (int i = 0; i < 16; i++) rd(AW'(i), NW'(1) << i);
        idle(2);

        wr(3, 16'h0004, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(3, 16'h0004, 8'h0F, 64'h0);
        rd(3, 16'h0004);
        idle(2);

        wr(5, 16'hFFFF, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5);
        rd(5, 16'h0001);
        rd(5, 16'h0011);
        rd(5, 16'h0000);
        idle(2);

        for (int i = 0; i < 4; i++) rd(AW'(i), 16'h0001);
        idle(3);

        wr(2, 16'h0010, 8'hA5, 64'h0123_4567_89AB_CDEF);
        rd(2, 16'h0010);
        wr(2, 16'h0030, 8'h3C, 64'hFEDC_BA98_7654_3210);
        rd(2, 16'h0020);
        rd(2, 16'h0010);
        idle(2);

        for (int i = 0; i < 400; i++) rand_step();
        idle(3);

        wr(9, 16'h0100, 8'hFF, 64'hDEAD_BEEF_0000_0001);
        rd(9, 16'h0100);
        idle(2);
        do_reset();
        for (int i = 0; i < 20; i++) rand_step();
        do_reset();
        for (int i = 0; i < NS; i++) rand_step();
        for (int i = 0; i < 8; i++) rd(AW'(i), NW'(1) << $urandom_range(0, NW - 1));
        rd(9, 16'h0100);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "timeout");
    end
endmodule
